// File: rtl/hub75_scan_if.sv
// Panel-side scan bus between the HUB75 sequencer (master) and the frame buffer / pin stage (slave).
// Widths are derived from the panel geometry so both ends agree.
interface hub75_scan_if #(
  parameter int COLS      = 64,
  parameter int SCAN_ROWS = 32,
  parameter int PLANES    = 1
);
  localparam int COL_W   = $clog2(COLS);
  localparam int ADDR_W  = $clog2(SCAN_ROWS);
  localparam int PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;

  logic               enable;
  logic [COL_W-1:0]   col;
  logic [ADDR_W-1:0]  scan_row;
  logic [PLANE_W-1:0] plane;
  logic [ADDR_W:0]    row_top;
  logic [ADDR_W:0]    row_bottom;
  logic               shift_en;
  logic               latch;
  logic               oe_n;
  logic [ADDR_W-1:0]  addr_out;
  logic               frame_start;
  logic               busy;

  modport master (
    input  enable,
    output col, scan_row, plane, row_top, row_bottom, shift_en, latch, oe_n,
           addr_out, frame_start, busy
  );

  modport slave (
    output enable,
    input  col, scan_row, plane, row_top, row_bottom, shift_en, latch, oe_n,
           addr_out, frame_start, busy
  );
endinterface

// File: rtl/hub75_scan_sequencer.sv
// HUB75 scan/timing sequencer: shifts one row-plane, blanks, latches, then displays it for a
// BCM-weighted hold time. All outputs are registered from the next-state decode.
//
//  state      | meaning
//  IDLE       | parked, panel dark, waiting for enable
//  SHIFT      | COLS pixels pushed out, col counts up
//  BLANK_PRE  | guard cycles before latch
//  LATCH      | one-cycle LAT pulse, panel address updated on entry
//  BLANK_POST | guard cycles after latch
//  HOLD       | panel lit for BASE_ON<<disp_plane cycles
module hub75_scan_sequencer #(
  parameter int COLS      = 64,
  parameter int SCAN_ROWS = 32,
  parameter int PLANES    = 1,
  parameter int BLANK_CYC = 2,
  parameter int BASE_ON   = 64
) (
  input  logic           clk,
  input  logic           rst,
  hub75_scan_if.master   bus
);
  localparam int COL_W    = $clog2(COLS);
  localparam int ADDR_W   = $clog2(SCAN_ROWS);
  localparam int PLANE_W  = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int HOLD_MAX = BASE_ON << (PLANES - 1);
  localparam int TMR_MAX  = (HOLD_MAX > BLANK_CYC) ? HOLD_MAX : BLANK_CYC;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, BLANK_PRE, LATCH, BLANK_POST, HOLD} state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   tmr, tmr_load;
  logic [COL_W-1:0]   col;
  logic [ADDR_W-1:0]  scan_row, addr_out;
  logic [PLANE_W-1:0] plane, disp_plane;
  logic               shift_en, latch, oe_n, frame_start, busy, frame_pending;

  always_comb begin
    state_nxt = state;
    tmr_load  = '0;
    unique case (state)
      IDLE:       if (bus.enable) state_nxt = SHIFT;
      SHIFT:      if (col == COL_W'(COLS - 1)) state_nxt = BLANK_PRE;
      BLANK_PRE:  if (tmr == '0) state_nxt = LATCH;
      LATCH:      state_nxt = BLANK_POST;
      BLANK_POST: if (tmr == '0) state_nxt = HOLD;
      HOLD:       if (tmr == '0) state_nxt = bus.enable ? SHIFT : IDLE;
      default:    state_nxt = IDLE;
    endcase
    // timer is loaded with length-1 on state entry and exits at terminal count 0
    case (state_nxt)
      BLANK_PRE, BLANK_POST: tmr_load = TMR_W'(BLANK_CYC - 1);
      HOLD:                  tmr_load = (TMR_W'(BASE_ON) << disp_plane) - TMR_W'(1);
      default:               tmr_load = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tmr           <= '0;
      col           <= '0;
      scan_row      <= '0;
      plane         <= '0;
      disp_plane    <= '0;
      addr_out      <= '0;
      shift_en      <= 1'b0;
      latch         <= 1'b0;
      oe_n          <= 1'b1;
      busy          <= 1'b0;
      frame_start   <= 1'b0;
      frame_pending <= 1'b1;
    end else begin
      state    <= state_nxt;
      shift_en <= (state_nxt == SHIFT);
      latch    <= (state_nxt == LATCH);
      oe_n     <= (state_nxt != HOLD);
      busy     <= (state_nxt != IDLE);

      if (state_nxt != state) tmr <= tmr_load;
      else if (tmr != '0)     tmr <= tmr - TMR_W'(1);

      if (state == SHIFT && state_nxt == SHIFT) col <= col + COL_W'(1);
      else                                      col <= '0;

      frame_start <= 1'b0;
      if (state_nxt == SHIFT && state != SHIFT && frame_pending) begin
        frame_start   <= 1'b1;
        frame_pending <= 1'b0;
      end

      // panel address only moves while the panel is blanked
      if (state_nxt == LATCH && state != LATCH) begin
        addr_out   <= scan_row;
        disp_plane <= plane;
      end

      if (state == LATCH) begin
        if (plane == PLANE_W'(PLANES - 1)) begin
          plane <= '0;
          if (scan_row == ADDR_W'(SCAN_ROWS - 1)) begin
            scan_row      <= '0;
            frame_pending <= 1'b1;
          end else begin
            scan_row <= scan_row + ADDR_W'(1);
          end
        end else begin
          plane <= plane + PLANE_W'(1);
        end
      end
    end
  end

  assign bus.col         = col;
  assign bus.scan_row    = scan_row;
  assign bus.plane       = plane;
  assign bus.row_top     = {1'b0, scan_row};
  assign bus.row_bottom  = {1'b1, scan_row};
  assign bus.shift_en    = shift_en;
  assign bus.latch       = latch;
  assign bus.oe_n        = oe_n;
  assign bus.addr_out    = addr_out;
  assign bus.frame_start = frame_start;
  assign bus.busy        = busy;
endmodule
